// File: rtl/sram_arb_pkg.sv
// Shared types and default timing for the two-port SRAM arbiter.
// Optional build macro used by the arbiter: SRAM_ARB_PERF_EN.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_TURN     = 3'd5
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int DEF_ADDR_W       = 18;
  localparam int DEF_RD_CYCLES    = 3;
  localparam int DEF_WE_CYCLES    = 2;
  localparam int DEF_MAX_A_STREAK = 4;

  // Strobe-length counter and streak counter widths
  localparam int CNT_W    = 8;
  localparam int STREAK_W = 4;

endpackage

// File: rtl/sram_arbiter_seq.sv
// Strobe/timing FSM for one asynchronous SRAM access (read or write),
// including the one-cycle bus turnaround after every access.
module sram_access_seq
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int RD_CYCLES = DEF_RD_CYCLES,
  parameter int WE_CYCLES = DEF_WE_CYCLES
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic              idle_o,
  output logic              done_o,
  output logic              done_rd_o,
  output logic [7:0]        rdata_o,
  output logic              ram_cs_b_o,
  output logic              ram_oe_b_o,
  output logic              ram_we_b_o,
  output logic [ADDR_W-1:0] ram_adr_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_dout_en_o,
  input  logic [7:0]        ram_din_i
);

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WE_LOAD = CNT_W'(WE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cs_q, cs_d;
  logic               oe_q, oe_d;
  logic               we_q, we_d;
  logic               den_q, den_d;
  logic [ADDR_W-1:0]  adr_q, adr_d;
  logic [7:0]         dout_q, dout_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
    oe_d    = oe_q;
    we_d    = we_q;
    den_d   = den_q;
    adr_d   = adr_q;
    dout_d  = dout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          adr_d  = addr_i;
          dout_d = wdata_i;
          cs_d   = 1'b0;
          if (we_i) begin
            state_d = ST_WR_SETUP;
            den_d   = 1'b1;
          end else begin
            state_d = ST_RD;
            oe_d    = 1'b0;
            cnt_d   = RD_LOAD;
          end
        end
      end
      ST_RD: begin
        if (cnt_q == '0) begin
          state_d = ST_TURN;
          cs_d    = 1'b1;
          oe_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WR_SETUP: begin
        state_d = ST_WR_PULSE;
        we_d    = 1'b0;
        cnt_d   = WE_LOAD;
      end
      ST_WR_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_WR_HOLD;
          we_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WR_HOLD: begin
        // Data stays driven for one cycle after WE rises to meet hold time
        state_d = ST_TURN;
        cs_d    = 1'b1;
        den_d   = 1'b0;
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b1;
        oe_d    = 1'b1;
        we_d    = 1'b1;
        den_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cs_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      den_q   <= 1'b0;
      adr_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      den_q   <= den_d;
      adr_q   <= adr_d;
      dout_q  <= dout_d;
    end
  end

  // done_o flags the edge that completes the access; rdata_o is what the
  // caller must capture on that edge for a read.
  assign idle_o        = (state_q == ST_IDLE);
  assign done_rd_o     = (state_q == ST_RD) && (cnt_q == '0);
  assign done_o        = done_rd_o || (state_q == ST_WR_HOLD);
  assign rdata_o       = ram_din_i;
  assign ram_cs_b_o    = cs_q;
  assign ram_oe_b_o    = oe_q;
  assign ram_we_b_o    = we_q;
  assign ram_adr_o     = adr_q;
  assign ram_dout_o    = dout_q;
  assign ram_dout_en_o = den_q;

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter for the external 8-bit SRAM: port A has priority, port B
// is forced after MAX_A_STREAK A grants. Optional counters: SRAM_ARB_PERF_EN.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int RD_CYCLES    = DEF_RD_CYCLES,
  parameter int WE_CYCLES    = DEF_WE_CYCLES,
  parameter int MAX_A_STREAK = DEF_MAX_A_STREAK
) (
  input  logic              clk100,
  input  logic              hard_reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_wdata,
  output logic [7:0]        a_rdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_wdata,
  output logic [7:0]        b_rdata,
  output logic              b_ack,
  output logic              ram_cs_b,
  output logic              ram_oe_b,
  output logic              ram_we_b,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [7:0]        ram_dout,
  output logic              ram_dout_en,
  input  logic [7:0]        ram_din
`ifdef SRAM_ARB_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [15:0]       perf_a_grants,
  output logic [15:0]       perf_b_grants,
  output logic [7:0]        perf_b_wait_max
`endif
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_A_STREAK);

  logic              seq_idle, seq_done, seq_done_rd;
  logic [7:0]        seq_rdata;
  logic              a_win, b_win, start;
  logic              start_we;
  logic [ADDR_W-1:0] start_addr;
  logic [7:0]        start_wdata;

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                sel_q, sel_d;
  logic                a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [7:0]          a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  always_comb begin
    b_win       = seq_idle && b_req &&
                  (!a_req || ((MAX_A_STREAK != 0) && (streak_q == STREAK_MAX)));
    a_win       = seq_idle && a_req && !b_win;
    start       = a_win || b_win;
    start_we    = b_win ? b_we    : a_we;
    start_addr  = b_win ? b_addr  : a_addr;
    start_wdata = b_win ? b_wdata : a_wdata;
  end

  // Streak only grows while B is actually waiting; any idle slot without
  // B pending, or a B grant, resets it.
  always_comb begin
    streak_d = streak_q;
    if (seq_idle) begin
      if (a_win && b_req) begin
        streak_d = (streak_q < STREAK_MAX) ? streak_q + 1'b1 : streak_q;
      end else begin
        streak_d = '0;
      end
    end
    sel_d     = start ? (b_win ? SEL_B : SEL_A) : sel_q;
    a_ack_d   = seq_done && (sel_q == SEL_A);
    b_ack_d   = seq_done && (sel_q == SEL_B);
    a_rdata_d = (seq_done_rd && (sel_q == SEL_A)) ? seq_rdata : a_rdata_q;
    b_rdata_d = (seq_done_rd && (sel_q == SEL_B)) ? seq_rdata : b_rdata_q;
  end

  always_ff @(posedge clk100 or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      streak_q  <= '0;
      sel_q     <= SEL_A;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      streak_q  <= streak_d;
      sel_q     <= sel_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_ack   = a_ack_q;
  assign b_ack   = b_ack_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

  sram_access_seq #(
    .ADDR_W    (ADDR_W),
    .RD_CYCLES (RD_CYCLES),
    .WE_CYCLES (WE_CYCLES)
  ) u_seq (
    .clk_i         (clk100),
    .rst_ni        (hard_reset_n),
    .start_i       (start),
    .we_i          (start_we),
    .addr_i        (start_addr),
    .wdata_i       (start_wdata),
    .idle_o        (seq_idle),
    .done_o        (seq_done),
    .done_rd_o     (seq_done_rd),
    .rdata_o       (seq_rdata),
    .ram_cs_b_o    (ram_cs_b),
    .ram_oe_b_o    (ram_oe_b),
    .ram_we_b_o    (ram_we_b),
    .ram_adr_o     (ram_adr),
    .ram_dout_o    (ram_dout),
    .ram_dout_en_o (ram_dout_en),
    .ram_din_i     (ram_din)
  );

`ifdef SRAM_ARB_PERF_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [15:0] pa_q, pa_d, pb_q, pb_d;
  logic [7:0]  wmax_q, wmax_d, wcnt_q, wcnt_d;
  logic        b_busy;

  // Wait counts edges where B is pending but neither granted nor being served
  always_comb begin
    b_busy = !seq_idle && (sel_q == SEL_B);
    wcnt_d = (b_win || !b_req || b_busy) ? 8'd0 : sat_inc8(wcnt_q);
    pa_d   = pa_q;
    pb_d   = pb_q;
    wmax_d = wmax_q;
    if (perf_clr) begin
      pa_d   = '0;
      pb_d   = '0;
      wmax_d = '0;
    end else begin
      if (a_win) pa_d = sat_inc16(pa_q);
      if (b_win) begin
        pb_d = sat_inc16(pb_q);
        if (wcnt_q > wmax_q) wmax_d = wcnt_q;
      end
    end
  end

  always_ff @(posedge clk100 or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      pa_q   <= '0;
      pb_q   <= '0;
      wmax_q <= '0;
      wcnt_q <= '0;
    end else begin
      pa_q   <= pa_d;
      pb_q   <= pb_d;
      wmax_q <= wmax_d;
      wcnt_q <= wcnt_d;
    end
  end

  assign perf_a_grants   = pa_q;
  assign perf_b_grants   = pb_q;
  assign perf_b_wait_max = wmax_q;
`endif

endmodule
